// File: rtl/wb_data_master.sv
// Wishbone B4 classic master for the single-cycle core's data port.
// Each load or store becomes one Wishbone bus cycle; Stall freezes the core
// until the cycle has terminated. Optional bus-cycle timeout is compiled in
// when the macro WB_TIMEOUT_EN is defined.
module wb_data_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  MemStrb,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } state_e;

  state_e state, next_state;

  logic req;
  logic timeout;
  logic abort;
  logic finish;

  // Reject out-of-range timeout settings at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
    $error("wb_data_master: TIMEOUT_CYCLES must be in 2..1024");
  end

  assign req = MemWrite | MemRead;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] tmo_cnt;

  // Count unterminated BUS cycles; cleared while idle so it starts at zero on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != StBus) begin
      tmo_cnt <= '0;
    end else if (!wb_ack_i && !wb_err_i) begin
      tmo_cnt <= tmo_cnt + CntW'(1);
    end
  end

  // Final permitted BUS cycle reached with no termination seen so far.
  assign timeout = (state == StBus) && (tmo_cnt == CntLast);
`else
  assign timeout = 1'b0;
`endif

  // Error beats ack; an ack in the final timeout cycle still completes normally.
  assign abort  = wb_err_i | (timeout & ~wb_ack_i);
  assign finish = wb_ack_i | abort;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= StIdle;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      StIdle: begin
        if (req) begin
          next_state = StBus;
        end
      end
      StBus: begin
        if (finish) begin
          next_state = StDone;
        end
      end
      StDone: begin
        next_state = StIdle;
      end
      default: begin
        next_state = StIdle;
      end
    endcase
  end

  // Outputs decoded from state; cyc/stb drop with reset because state does.
  always_comb begin
    wb_cyc_o = (state == StBus);
    wb_stb_o = (state == StBus);
    Stall    = req & (state != StDone);
  end

  // Request capture, load data and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      ReadData <= '0;
      BusErr   <= 1'b0;
    end else begin
      BusErr <= (state == StBus) & abort;
      if (state == StIdle && req) begin
        wb_we_o  <= MemWrite;
        wb_adr_o <= DataAdr;
        wb_dat_o <= WriteData;
        wb_sel_o <= MemWrite ? MemStrb : 4'hF;
      end
      if (state == StBus && !wb_we_o) begin
        if (abort) begin
          ReadData <= '0;
        end else if (wb_ack_i) begin
          ReadData <= wb_dat_i;
        end
      end
    end
  end

endmodule
